// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: one requester's port to the data-memory arbiter
interface dm_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic                req;
  logic                we;
  logic [DATA_W/8-1:0] be;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic                ack;
  logic [DATA_W-1:0]   rdata;
  modport master (output req, we, be, addr, wdata, input ack, rdata);
  modport slave  (input req, we, be, addr, wdata, output ack, rdata);
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin sharing of the single-port data memory between two requesters,
// with read-modify-write for partial stores
module dm_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  dm_arbiter_if.slave       m0,
  dm_arbiter_if.slave       m1,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_din,
  output logic              dm_DMWr,
  input  logic [DATA_W-1:0] dm_dout,
  output logic              busy
);
  localparam int BE_W = DATA_W / 8;
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ACCESS = 3'd1;
  localparam logic [2:0] RMW_RD = 3'd2;
  localparam logic [2:0] RMW_WR = 3'd3;
  localparam logic [2:0] ACK    = 3'd4;

  logic [2:0]        state;
  logic              own, last, we;
  logic [BE_W-1:0]   be;
  logic [ADDR_W-3:0] widx;
  logic [DATA_W-1:0] wdata, merge, mix, rd0, rd1;
  logic              g_v, gnt, g_we, full_wr, mem_act;
  logic [BE_W-1:0]   g_be;
  logic [ADDR_W-3:0] g_widx;
  logic [DATA_W-1:0] g_wdata;

  // gnt selects m1; on a tie the master that did not win last time gets it
  assign g_v     = m0.req | m1.req;
  assign gnt     = (m0.req & m1.req) ? ~last : m1.req;
  assign g_we    = gnt ? m1.we : m0.we;
  assign g_be    = gnt ? m1.be : m0.be;
  assign g_widx  = gnt ? m1.addr[ADDR_W-1:2] : m0.addr[ADDR_W-1:2];
  assign g_wdata = gnt ? m1.wdata : m0.wdata;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      own   <= 1'b0;
      we    <= 1'b0;
      be    <= '0;
      widx  <= '0;
      wdata <= '0;
      merge <= '0;
      rd0   <= '0;
      rd1   <= '0;
    end else begin
      case (state)
        IDLE: if (g_v) begin
          own   <= gnt;
          last  <= gnt;
          we    <= g_we;
          be    <= g_be;
          widx  <= g_widx;
          wdata <= g_wdata;
          state <= (g_we && g_be != '1 && g_be != '0) ? RMW_RD : ACCESS;
        end
        ACCESS: begin
          if (!we && !own) rd0 <= dm_dout;
          if (!we && own) rd1 <= dm_dout;
          state <= ACK;
        end
        RMW_RD: begin
          merge <= dm_dout;
          state <= RMW_WR;
        end
        RMW_WR: state <= ACK;
        default: state <= IDLE;
      endcase
    end

  for (genvar i = 0; i < BE_W; i++) begin : g_lane
    assign mix[8*i +: 8] = be[i] ? wdata[8*i +: 8] : merge[8*i +: 8];
  end

  // memory signals are held at zero outside the three memory-facing states
  assign full_wr  = state == ACCESS && we && be == '1;
  assign mem_act  = state == ACCESS || state == RMW_RD || state == RMW_WR;
  assign dm_addr  = mem_act ? {widx, 2'b00} : '0;
  assign dm_DMWr  = full_wr || state == RMW_WR;
  assign dm_din   = full_wr ? wdata : state == RMW_WR ? mix : '0;
  assign m0.ack   = state == ACK && !own;
  assign m1.ack   = state == ACK && own;
  assign m0.rdata = rd0;
  assign m1.rdata = rd1;
  assign busy     = state != IDLE;
endmodule
